// File: rtl/mul8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller
// and its partial-product unit.
package mul8_seq_pkg;

    localparam int OP_W      = 8;
    localparam int NIB_W     = 4;
    localparam int PROD_W    = 16;
    localparam int PP_MID_SH = 4;
    localparam int PP_HI_SH  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/approx_mul8_seq_if.sv
// Operand/result handshake bundle for approx_mul8_seq; the producer/consumer
// side uses the master modport, the multiplier uses slave.
interface approx_mul8_seq_if;
    import mul8_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] prod;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, prod, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, prod, busy
    );

endinterface

// File: rtl/mul8_pp_unit.sv
// ap4/ap3 4x4 sub-multiplier pair sharing the x nibble. Define
// MUL8_SEQ_EXACT_EN to replace both with exact 4x4 products.
module mul8_pp_unit
    import mul8_seq_pkg::*;
(
    input  logic [NIB_W-1:0]  x,
    input  logic [NIB_W-1:0]  y_lo,
    input  logic [NIB_W-1:0]  y_hi,
    output logic [2*NIB_W-1:0] p4,
    output logic [2*NIB_W-1:0] p3
);

    logic [2*NIB_W-1:0] e4;
    logic [2*NIB_W-1:0] e3;

    assign e4 = {4'b0, y_lo} * {4'b0, x};
    assign e3 = {4'b0, y_hi} * {4'b0, x};

`ifdef MUL8_SEQ_EXACT_EN
    assign p4 = e4;
    assign p3 = e3;
`else
    // ap4 drops partial-product column 0; ap3 drops columns 0 and 1.
    logic [2*NIB_W-1:0] col0_3;
    logic [2*NIB_W-1:0] col1_3;

    assign col0_3 = {7'b0, y_hi[0] & x[0]};
    assign col1_3 = ({7'b0, y_hi[1] & x[0]} + {7'b0, y_hi[0] & x[1]}) << 1;

    assign p4 = e4 & 8'hFE;
    assign p3 = e3 - col0_3 - col1_3;
`endif

endmodule

// File: rtl/approx_mul8_seq.sv
// Sequential 8x8 multiplier: one ap4/ap3 pair time-shared over two passes
// (P0: low b nibble, P1: high b nibble) with shift-add accumulation.
module approx_mul8_seq
    import mul8_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    approx_mul8_seq_if.slave bus
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_a_q, op_a_d;
    logic [OP_W-1:0]     op_b_q, op_b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;

    logic                in_ready;
    logic                accept;
    logic [NIB_W-1:0]    x_nib;
    logic [2*NIB_W-1:0]  p4;
    logic [2*NIB_W-1:0]  p3;

    // 17-bit add of a shifted partial product, wrapped to 16 bits.
    function automatic logic [PROD_W-1:0] add_pp(
        input logic [PROD_W-1:0]  base,
        input logic [2*NIB_W-1:0] pp,
        input int                 sh
    );
        logic [PROD_W:0] ext;
        logic [PROD_W:0] sum;
        ext       = '0;
        ext[7:0]  = pp;
        sum       = {1'b0, base} + (ext << sh);
        return sum[PROD_W-1:0];
    endfunction

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == P0) || (state_q == P1);
    assign bus.prod      = acc_q;

    assign x_nib = (state_q == P1) ? op_b_q[7:4] : op_b_q[3:0];

    mul8_pp_unit u_pp (
        .x    (x_nib),
        .y_lo (op_a_q[3:0]),
        .y_hi (op_a_q[7:4]),
        .p4   (p4),
        .p3   (p3)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = P0;
                    op_a_d  = bus.a;
                    op_b_d  = bus.b;
                end
            end
            P0: begin
                state_d = P1;
                acc_d   = add_pp(add_pp('0, p4, 0), p3, PP_MID_SH);
            end
            P1: begin
                state_d = DONE;
                acc_d   = add_pp(add_pp(acc_q, p4, PP_MID_SH), p3, PP_HI_SH);
            end
            DONE: begin
                // Release and a new accept may share the same edge.
                if (bus.out_ready) begin
                    if (accept) begin
                        state_d = P0;
                        op_a_d  = bus.a;
                        op_b_d  = bus.b;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
        end
    end

endmodule
